// File: rtl/gate_truth_checker.sv
// Sequential truth-table checker for small combinational gates: walks every input
// vector, samples the gate after a settle window and tallies mismatches.
module gate_truth_checker #(
  parameter int unsigned          N_IN   = 2,
  parameter int unsigned          SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int unsigned ERR_W    = N_IN + 1;
  localparam int unsigned CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned LAST_IDX = (1 << N_IN) - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;

  logic              sample_c;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_inc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    sample_c   = (cnt_q == CNT_W'(SETTLE - 1));
    mismatch_c = (dut_out != EXP_TT[idx_q]);
    err_inc_c  = err_q + ERR_W'(mismatch_c);

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run wipes the previous result on the accept edge
        if (start) begin
          state_d = S_SETTLE;
          stim_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      S_SETTLE: begin
        if (sample_c) begin
          if (mismatch_c) begin
            err_d = err_inc_c;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = idx_q;
            end
          end
          cnt_d = '0;
          if (idx_q == N_IN'(LAST_IDX)) begin
            state_d = S_DONE;
            stim_d  = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc_c == '0);
          end else begin
            idx_d  = idx_q + N_IN'(1);
            stim_d = idx_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: several gate models against a NOR table,
// plus an OR-table instance and a 1-input inverter instance.
module tb_gate_truth_checker;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Main instance (defaults: NOR table, 2 inputs, settle 2)
  logic       start_main, dut_out_main;
  logic [1:0] stim_main, ffvec_main;
  logic       busy_main, done_main, pass_main, ffv_main;
  logic [2:0] err_main;
  int         sel;

  // OR table instance driven by a real OR gate
  logic       start_or, dut_out_or;
  logic [1:0] stim_or, ffvec_or;
  logic       busy_or, done_or, pass_or, ffv_or;
  logic [2:0] err_or;

  // Inverter instance, 1 input, settle 1
  logic       start_inv, dut_out_inv;
  logic [0:0] stim_inv, ffvec_inv;
  logic       busy_inv, done_inv, pass_inv, ffv_inv;
  logic [1:0] err_inv;

  gate_truth_checker u_main (
    .clk(clk), .rst(rst), .start(start_main), .dut_out(dut_out_main),
    .stim(stim_main), .busy(busy_main), .done(done_main), .pass(pass_main),
    .err_count(err_main), .first_fail_valid(ffv_main), .first_fail_vec(ffvec_main)
  );

  gate_truth_checker #(.N_IN(2), .SETTLE(2), .EXP_TT(4'b1110)) u_or (
    .clk(clk), .rst(rst), .start(start_or), .dut_out(dut_out_or),
    .stim(stim_or), .busy(busy_or), .done(done_or), .pass(pass_or),
    .err_count(err_or), .first_fail_valid(ffv_or), .first_fail_vec(ffvec_or)
  );

  gate_truth_checker #(.N_IN(1), .SETTLE(1), .EXP_TT(2'b01)) u_inv (
    .clk(clk), .rst(rst), .start(start_inv), .dut_out(dut_out_inv),
    .stim(stim_inv), .busy(busy_inv), .done(done_inv), .pass(pass_inv),
    .err_count(err_inv), .first_fail_valid(ffv_inv), .first_fail_vec(ffvec_inv)
  );

  // 0: NOR, 1: stuck-at-1, 2: OR, 3: AND
  function automatic logic gate_fn(input int s, input logic [1:0] v);
    case (s)
      0:       return ~(v[1] | v[0]);
      1:       return 1'b1;
      2:       return v[1] | v[0];
      default: return v[1] & v[0];
    endcase
  endfunction

  assign dut_out_main = gate_fn(sel, stim_main);
  assign dut_out_or   = stim_or[1] | stim_or[0];
  assign dut_out_inv  = ~stim_inv[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_main_cleared(input string tag);
    check_eq({tag, "_stim"}, 32'(stim_main), 0);
    check_eq({tag, "_busy"}, 32'(busy_main), 0);
    check_eq({tag, "_done"}, 32'(done_main), 0);
    check_eq({tag, "_pass"}, 32'(pass_main), 0);
    check_eq({tag, "_err"},  32'(err_main),  0);
    check_eq({tag, "_ffv"},  32'(ffv_main),  0);
    check_eq({tag, "_ffvec"}, 32'(ffvec_main), 0);
  endtask

  // cycles = edges from accept to done (-1 when aborted by reset)
  task automatic do_run(input int s, input int repulse_at, input int rst_at, output int cycles);
    sel = s;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    cycles = 0;
    check_eq("accept_busy", 32'(busy_main), 1);
    check_eq("accept_done", 32'(done_main), 0);
    check_eq("accept_err",  32'(err_main),  0);
    check_eq("accept_ffv",  32'(ffv_main),  0);
    while (!done_main && cycles < 50) begin
      if (cycles < 8) check_eq("stim_hold", 32'(stim_main), 32'(cycles / 2));
      if (cycles == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_main_cleared("midrst");
        rst = 1'b0;
        cycles = -1;
        return;
      end
      start_main = (cycles == repulse_at);
      @(negedge clk);
      cycles++;
    end
    start_main = 1'b0;
  endtask

  initial begin
    int c;
    checks = 0;
    failures = 0;
    sel = 0;
    rst = 1'b1;
    start_main = 1'b0;
    start_or = 1'b0;
    start_inv = 1'b0;
    repeat (2) @(negedge clk);
    check_main_cleared("reset");
    rst = 1'b0;

    do_run(0, -1, -1, c);
    check_eq("nor_cycles", 32'(c), 8);
    check_eq("nor_pass", 32'(pass_main), 1);
    check_eq("nor_err", 32'(err_main), 0);
    check_eq("nor_ffv", 32'(ffv_main), 0);
    check_eq("nor_busy", 32'(busy_main), 0);
    repeat (3) @(negedge clk);
    check_eq("nor_done_hold", 32'(done_main), 1);
    check_eq("nor_pass_hold", 32'(pass_main), 1);

    do_run(1, -1, -1, c);
    check_eq("stuck_cycles", 32'(c), 8);
    check_eq("stuck_err", 32'(err_main), 3);
    check_eq("stuck_ffv", 32'(ffv_main), 1);
    check_eq("stuck_ffvec", 32'(ffvec_main), 1);
    check_eq("stuck_pass", 32'(pass_main), 0);

    do_run(2, -1, -1, c);
    check_eq("or_cycles", 32'(c), 8);
    check_eq("or_err", 32'(err_main), 4);
    check_eq("or_ffvec", 32'(ffvec_main), 0);
    check_eq("or_ffv", 32'(ffv_main), 1);
    check_eq("or_pass", 32'(pass_main), 0);

    do_run(3, 3, -1, c);
    check_eq("and_repulse_cycles", 32'(c), 8);
    check_eq("and_err", 32'(err_main), 2);
    check_eq("and_ffvec", 32'(ffvec_main), 0);
    check_eq("and_pass", 32'(pass_main), 0);

    do_run(0, -1, -1, c);
    check_eq("rerun_cycles", 32'(c), 8);
    check_eq("rerun_err", 32'(err_main), 0);
    check_eq("rerun_pass", 32'(pass_main), 1);

    do_run(1, -1, 5, c);
    check_eq("rst_abort", 32'(c), -1);
    repeat (3) @(negedge clk);
    check_eq("rst_idle_busy", 32'(busy_main), 0);
    check_eq("rst_idle_done", 32'(done_main), 0);

    do_run(0, -1, -1, c);
    check_eq("post_rst_cycles", 32'(c), 8);
    check_eq("post_rst_pass", 32'(pass_main), 1);

    @(negedge clk);
    start_or = 1'b1;
    @(negedge clk);
    start_or = 1'b0;
    c = 0;
    while (!done_or && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_eq("ortt_cycles", 32'(c), 8);
    check_eq("ortt_pass", 32'(pass_or), 1);
    check_eq("ortt_err", 32'(err_or), 0);

    @(negedge clk);
    start_inv = 1'b1;
    @(negedge clk);
    start_inv = 1'b0;
    c = 0;
    while (!done_inv && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_eq("inv_cycles", 32'(c), 2);
    check_eq("inv_pass", 32'(pass_inv), 1);
    check_eq("inv_err", 32'(err_inv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
